// File: rtl/doodle_pkg.sv
// Shared types and constants for the platform spawner slice.
package doodle_pkg;

  localparam int COORD_W = 32;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } platform_slot_t;

  typedef enum logic [1:0] {INIT, IDLE, SCAN, FILL} spawner_state_t;

  // Maps the 16-bit LFSR value onto 0 .. span-1 as a left-edge X.
  function automatic logic [COORD_W-1:0] xgen(input logic [15:0] lfsr, input int span);
    return COORD_W'((48'(lfsr) * 48'(span)) >> 16);
  endfunction

endpackage

// File: rtl/platform_lfsr.sv
// 16-bit Galois LFSR; value_o is the current state, steps only when adv_i is high.
module platform_lfsr
  import doodle_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv_i,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (reset)      lfsr_q <= SEED;
    else if (adv_i) lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/platform_spawner.sv
// Platform pool: INIT fills every slot, each new view retires slots below min_y and respawns above top_y.
// Optional PLATFORM_JITTER_EN adds lfsr[3:0] to each spawn gap.
module platform_spawner
  import doodle_pkg::*;
#(
  parameter int          SCREEN_WIDTH  = 640,
  parameter int          SCREEN_HEIGHT = 480,
  parameter int          BLOCK_WIDTH   = 64,
  parameter int          BLOCK_HEIGHT  = 16,
  parameter int          NUM_SLOTS     = 8,
  parameter int          SPACING       = 60,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  localparam int         IDX_W         = $clog2(NUM_SLOTS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_view,
  input  logic [COORD_W-1:0] min_y,
  output logic               busy,
  output logic [COORD_W-1:0] top_y,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic               rd_active,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y
);

  localparam int X_SPAN = SCREEN_WIDTH - BLOCK_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  if (NUM_SLOTS < 2 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0)
    $error("NUM_SLOTS must be a power of 2 and at least 2");
  if (LFSR_SEED == 16'h0000)
    $error("LFSR_SEED must be nonzero");
  if (BLOCK_WIDTH >= SCREEN_WIDTH || BLOCK_HEIGHT > SCREEN_HEIGHT)
    $error("platform block must fit on the screen");

  spawner_state_t     state_q;
  logic [IDX_W-1:0]   scan_idx_q;
  logic               pending_q;
  logic [COORD_W-1:0] min_y_q, top_y_q;
  logic               busy_q, rd_valid_q, rd_active_q;
  logic [COORD_W-1:0] rd_x_q, rd_y_q;
  platform_slot_t     slots_q [NUM_SLOTS];

  logic [15:0]        lfsr;
  logic               lfsr_adv;
  platform_slot_t     cur;
  logic [COORD_W-1:0] jitter, spawn_x, spawn_y, init_y;

  // The LFSR steps exactly when a platform is written.
  always_comb begin
    cur      = slots_q[scan_idx_q];
    lfsr_adv = (state_q == INIT) || (state_q == FILL && !cur.active);
`ifdef PLATFORM_JITTER_EN
    jitter   = {28'b0, lfsr[3:0]};
`else
    jitter   = '0;
`endif
    spawn_x  = xgen(lfsr, X_SPAN);
    spawn_y  = top_y_q + COORD_W'(SPACING) + jitter;
    init_y   = COORD_W'(scan_idx_q) * COORD_W'(SPACING);
  end

  platform_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .adv_i   (lfsr_adv),
    .value_o (lfsr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      scan_idx_q  <= '0;
      pending_q   <= 1'b0;
      min_y_q     <= '0;
      top_y_q     <= '0;
      busy_q      <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_active_q <= 1'b0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
    end else begin
      // Read port sees contents as they stood before this edge's update.
      rd_active_q <= slots_q[rd_idx].active;
      rd_x_q      <= slots_q[rd_idx].x;
      rd_y_q      <= slots_q[rd_idx].y;

      if (new_view && state_q != IDLE) pending_q <= 1'b1;

      case (state_q)
        INIT: begin
          slots_q[scan_idx_q] <= '{active: 1'b1, x: spawn_x, y: init_y};
          scan_idx_q          <= scan_idx_q + 1'b1;
          if (scan_idx_q == LAST_IDX) begin
            top_y_q    <= COORD_W'((NUM_SLOTS - 1) * SPACING);
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b1;
          end
        end
        IDLE: begin
          if (new_view || pending_q) begin
            min_y_q    <= min_y;
            pending_q  <= 1'b0;
            scan_idx_q <= '0;
            state_q    <= SCAN;
            busy_q     <= 1'b1;
          end
        end
        SCAN: begin
          if (cur.active && cur.y < min_y_q) slots_q[scan_idx_q].active <= 1'b0;
          scan_idx_q <= scan_idx_q + 1'b1;
          if (scan_idx_q == LAST_IDX) state_q <= FILL;
        end
        FILL: begin
          if (!cur.active) begin
            slots_q[scan_idx_q] <= '{active: 1'b1, x: spawn_x, y: spawn_y};
            top_y_q             <= spawn_y;
          end
          scan_idx_q <= scan_idx_q + 1'b1;
          if (scan_idx_q == LAST_IDX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign busy      = busy_q;
  assign top_y     = top_y_q;
  assign rd_valid  = rd_valid_q;
  assign rd_active = rd_active_q;
  assign rd_x      = rd_x_q;
  assign rd_y      = rd_y_q;

endmodule

// File: tb/tb_platform_spawner.sv
// Directed bench for platform_spawner at default parameters; expected X/Y values hand-computed from the LFSR sequence.
module tb_platform_spawner;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_view;
  logic [31:0] min_y;
  logic        busy;
  logic [31:0] top_y;
  logic [2:0]  rd_idx;
  logic        rd_valid, rd_active;
  logic [31:0] rd_x, rd_y;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  platform_spawner dut (
    .clk       (clk),
    .reset     (reset),
    .new_view  (new_view),
    .min_y     (min_y),
    .busy      (busy),
    .top_y     (top_y),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_active (rd_active),
    .rd_x      (rd_x),
    .rd_y      (rd_y)
  );

  // lfsr[3:0] of LFSR step k (seed is step 0), used only when jitter is built in.
`ifdef PLATFORM_JITTER_EN
  localparam logic [3:0] JN [17] = '{4'h1, 4'h0, 4'h8, 4'hC, 4'hE, 4'h7, 4'h3, 4'h9,
                                     4'h4, 4'h2, 4'h1, 4'h8, 4'hC, 4'h6, 4'hB, 4'h5, 4'h2};
`else
  localparam logic [3:0] JN [17] = '{default: 4'h0};
`endif

  // X for LFSR steps 0,1,7,8,9,10,15,16 (value*576>>16).
  localparam int X0 = 388, X1 = 509, X7 = 534, X8 = 438, X9 = 219, X10 = 109, X15 = 429, X16 = 529;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic rd(input int i);
    rd_idx = 3'(i);
    @(negedge clk);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic [31:0] my);
    min_y    = my;
    new_view = 1'b1;
    @(negedge clk);
    new_view = 1'b0;
  endtask

  int          n, ones;
  logic [31:0] ey, etop, y0;

  initial begin
    reset = 1'b1; new_view = 1'b0; min_y = '0; rd_idx = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_active", 32'(rd_active), 0);
    chk("rst_x", rd_x, 0);
    chk("rst_y", rd_y, 0);
    chk("rst_top", top_y, 0);

    // Scenario 1: power-up fill.
    reset = 1'b0;
    busy_len(n);
    chk("init_busy_cycles", n, 8);
    rd(0);
    chk("s0_valid", 32'(rd_valid), 1);
    chk("s0_active", 32'(rd_active), 1);
    chk("s0_x", rd_x, X0);
    chk("s0_y", rd_y, 0);
    rd(1);
    chk("s1_x", rd_x, X1);
    chk("s1_y", rd_y, 60);
    rd(7);
    chk("s7_x", rd_x, X7);
    chk("s7_y", rd_y, 420);
    chk("init_top", top_y, 420);

    // Scenario 2: retire y<120, keep y==120.
    pulse(120);
    busy_len(n);
    chk("nv120_busy_cycles", n, 16);
    ey = 32'd420 + 60 + 32'(JN[8]);
    rd(0);
    chk("nv120_s0_y", rd_y, ey);
    chk("nv120_s0_x", rd_x, X8);
    ey = ey + 60 + 32'(JN[9]);
    rd(1);
    chk("nv120_s1_y", rd_y, ey);
    chk("nv120_s1_x", rd_x, X9);
    rd(2);
    chk("nv120_s2_kept", 32'(rd_active), 1);
    chk("nv120_s2_y", rd_y, 120);
    chk("nv120_top", top_y, ey);
    etop = ey;

    // Scenario 3: three pulses while busy merge into one extra pass using the later min_y.
    pulse(200);
    ones = 0;
    for (int s = 0; s < 45; s++) begin
      if (s == 16) chk("pend_gap_low", 32'(busy), 0);
      if (s == 17) chk("pend_second_start", 32'(busy), 1);
      if (busy) ones++;
      new_view = (s == 3 || s == 8 || s == 12);
      if (s == 5) min_y = 300;
      @(negedge clk);
    end
    new_view = 1'b0;
    chk("pend_total_busy", ones, 32);
    chk("pend_final_idle", 32'(busy), 0);
    ey = etop + 60 + 32'(JN[10]);
    rd(2);
    chk("pend_s2_y", rd_y, ey);
    chk("pend_s2_x", rd_x, X10);
    ey = ey + 60 + 32'(JN[11]);
    rd(3);
    chk("pend_s3_y", rd_y, ey);
    ey = ey + 60 + 32'(JN[12]);
    rd(4);
    chk("pend_s4_y", rd_y, ey);
    rd(5);
    chk("pend_s5_kept_y", rd_y, 300);
    chk("pend_top", top_y, ey);

    // Scenario 5: reset in the middle of FILL with a pending request outstanding.
    min_y    = 32'd5000;
    new_view = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 10; s++) begin
      new_view = (s == 2);
      @(negedge clk);
    end
    new_view = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 1);
    chk("midrst_valid", 32'(rd_valid), 0);
    chk("midrst_top", top_y, 0);
    chk("midrst_y", rd_y, 0);
    reset = 1'b0;
    busy_len(n);
    chk("reinit_busy_cycles", n, 8);
    ones = 0;
    for (int s = 0; s < 20; s++) begin
      if (busy) ones++;
      @(negedge clk);
    end
    chk("reinit_no_pending", ones, 0);
    rd(0);
    chk("reinit_s0_x", rd_x, X0);
    chk("reinit_s0_y", rd_y, 0);
    rd(7);
    chk("reinit_s7_y", rd_y, 420);
    chk("reinit_top", top_y, 420);

    // Scenario 4: everything retired, whole pool refilled in one pass.
    pulse(1000);
    busy_len(n);
    chk("all_busy_cycles", n, 16);
    ey = 32'd420;
    for (int i = 0; i < 8; i++) begin
      ey = ey + 60 + 32'(JN[8+i]);
      if (i == 0) y0 = ey;
      rd(i);
      chk($sformatf("all_s%0d_y", i), rd_y, ey);
    end
    chk("all_s7_x", rd_x, X15);
    chk("all_top", top_y, ey);
    etop = ey;

    // Nothing below min_y: no writes, LFSR and top_y hold.
    pulse(0);
    busy_len(n);
    chk("none_busy_cycles", n, 16);
    chk("none_top", top_y, etop);
    rd(0);
    chk("none_s0_y", rd_y, y0);

    // Retire only slot 0: its X must come from the next LFSR step, proving it did not advance.
    pulse(y0 + 1);
    busy_len(n);
    rd(0);
    chk("one_s0_x", rd_x, X16);
    chk("one_s0_y", rd_y, etop + 60 + 32'(JN[16]));
    chk("one_top", top_y, etop + 60 + 32'(JN[16]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
